// File: rtl/uart_tx.sv
// 8N1 serial transmitter: takes a parallel word on a one-cycle start request and
// shifts it out LSB first with start/stop framing at BaudDiv clocks per bit.
module uart_tx #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned BaudDiv   = 5208
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 start_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned BaudW = $clog2(BaudDiv);
  localparam int unsigned BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_end;

  assign baud_end = (baud_cnt_q == BaudLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Line value is computed one cycle ahead so the pin comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_i) begin
          state_d    = START;
          shift_d    = data_i;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + BaudW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BitLast) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BitW'(1);
            tx_d      = shift_d[0];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BaudW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          tx_d       = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + BaudW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
